// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : RV32M funct3 encodings, FSM states and sizing shared by the
//               multiply/divide unit and the ALU-control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  localparam int C_XLEN  = 32;
  localparam int C_ITER  = 32;
  localparam int C_CNT_W = 5;

  localparam logic [2:0] C_OP_MUL    = 3'd0;
  localparam logic [2:0] C_OP_MULH   = 3'd1;
  localparam logic [2:0] C_OP_MULHSU = 3'd2;
  localparam logic [2:0] C_OP_MULHU  = 3'd3;
  localparam logic [2:0] C_OP_DIV    = 3'd4;
  localparam logic [2:0] C_OP_DIVU   = 3'd5;
  localparam logic [2:0] C_OP_REM    = 3'd6;
  localparam logic [2:0] C_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

endpackage

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative RV32M multiply (shift-add) / divide (restoring) unit.
//               Results are produced 33 cycles after an accepted start; division
//               special cases complete in a single cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = C_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_neg64(input logic [2*XLEN-1:0] v);
    return -v;
  endfunction

  mdu_state_e          r_state;
  mdu_state_e          w_state_next;
  logic [2:0]          r_op;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic [C_CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic                w_last;
  logic [XLEN-1:0]     w_special_res;
  logic [XLEN-1:0]     w_load_a;
  logic [XLEN-1:0]     w_load_b;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_rem_sh;
  logic                w_ge;
  logic [XLEN-1:0]     w_rem_new;
  logic [2*XLEN-1:0]   w_div_next;
  logic [2*XLEN-1:0]   w_prod_fix;
  logic [XLEN-1:0]     w_quo_fix;
  logic [XLEN-1:0]     w_rem_fix;
  logic [XLEN-1:0]     w_final;

  // Operand decode for a start request
  always_comb begin
    w_accept   = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_sgn_a    = (op_i == C_OP_MULH) || (op_i == C_OP_MULHSU) ||
                 (op_i == C_OP_DIV)  || (op_i == C_OP_REM);
    w_sgn_b    = (op_i == C_OP_MULH) || (op_i == C_OP_DIV) || (op_i == C_OP_REM);
    w_div_zero = (B_i == '0);
    w_div_ovf  = ((op_i == C_OP_DIV) || (op_i == C_OP_REM)) &&
                 (A_i == C_INT_MIN) && (B_i == '1);
    w_special  = op_i[2] && (w_div_zero || w_div_ovf);
    w_load_a   = w_sgn_a ? f_abs(A_i) : A_i;
    w_load_b   = w_sgn_b ? f_abs(B_i) : B_i;
    // op_i[1] distinguishes remainder ops (6,7) from quotient ops (4,5)
    if (w_div_zero) w_special_res = op_i[1] ? A_i : '1;
    else            w_special_res = op_i[1] ? '0 : C_INT_MIN;
  end

  // One iteration step of each datapath; r_acc is {hi, lo}
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
    w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge       = (w_rem_sh >= {1'b0, r_opb});
    w_rem_new  = w_ge ? (w_rem_sh[XLEN-1:0] - r_opb) : w_rem_sh[XLEN-1:0];
    w_div_next = {w_rem_new, r_acc[XLEN-2:0], w_ge};
    w_last     = (r_cnt == C_CNT_W'(C_ITER - 1));
  end

  always_comb begin
    w_prod_fix = r_neg_res ? f_neg64(w_mul_next) : w_mul_next;
    w_quo_fix  = r_neg_res ? -w_div_next[XLEN-1:0] : w_div_next[XLEN-1:0];
    w_rem_fix  = r_neg_rem ? -w_div_next[2*XLEN-1:XLEN] : w_div_next[2*XLEN-1:XLEN];
    w_final    = w_rem_fix;
    unique case (r_op)
      C_OP_MUL:                          w_final = w_prod_fix[XLEN-1:0];
      C_OP_MULH, C_OP_MULHSU, C_OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
      C_OP_DIV, C_OP_DIVU:               w_final = w_quo_fix;
      default:                           w_final = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          if (!op_i[2])       w_state_next = S_MUL;
          else if (w_special) w_state_next = S_DONE;
          else                w_state_next = S_DIV;
        end else if (r_state == S_DONE) begin
          w_state_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (w_last) w_state_next = S_DONE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op      <= op_i;
        r_neg_res <= (w_sgn_a & A_i[XLEN-1]) ^ (w_sgn_b & B_i[XLEN-1]);
        r_neg_rem <= w_sgn_a & A_i[XLEN-1];
        r_cnt     <= '0;
        r_acc     <= {{XLEN{1'b0}}, w_load_a};
        r_opb     <= w_load_b;
        if (w_special) begin
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_result <= w_special_res;
        end else begin
          r_busy   <= 1'b1;
        end
      end else if (r_busy) begin
        r_cnt <= r_cnt + C_CNT_W'(1);
        r_acc <= (r_state == S_MUL) ? w_mul_next : w_div_next;
        if (w_last) begin
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_result <= w_final;
        end
      end
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed table-driven bench for mul_div_unit plus handshake
//               corner sequences (ignored start, back-to-back, mid-op reset).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .A_i      (A_i),
    .B_i      (B_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation from IDLE, then measure latency and busy length
  task automatic run_op(input vec_t v, input int idx);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    start_i = 1'b1;
    op_i    = v.op;
    A_i     = v.a;
    B_i     = v.b;
    tick();
    start_i = 1'b0;
    A_i     = ~v.a;
    B_i     = ~v.b;
    for (int n = 1; n <= 40; n++) begin
      if (busy_o) busy_cnt++;
      if (done_o) begin
        lat = n;
        break;
      end
      tick();
    end
    check($sformatf("vec%0d result", idx), result_o, v.exp);
    check($sformatf("vec%0d done latency", idx), 32'(lat), v.special ? 32'd1 : 32'd33);
    check($sformatf("vec%0d busy cycles", idx), 32'(busy_cnt), v.special ? 32'd0 : 32'd32);
    tick();
  endtask

  initial begin
    int lat;
    int busy_cnt;
    bit seen;

    vecs[0]  = '{C_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{C_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{C_OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0};
    vecs[3]  = '{C_OP_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[4]  = '{C_OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{C_OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{C_OP_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 1'b0};
    vecs[7]  = '{C_OP_REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 1'b0};
    vecs[8]  = '{C_OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{C_OP_REM,    32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1};
    vecs[10] = '{C_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[11] = '{C_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[12] = '{C_OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[13] = '{C_OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[14] = '{C_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[15] = '{C_OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0};
    vecs[16] = '{C_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[17] = '{C_OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0};
    vecs[18] = '{C_OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0};
    vecs[19] = '{C_OP_DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000, 1'b0};

    reset   = 1'b0;
    start_i = 1'b0;
    op_i    = 3'd0;
    A_i     = 32'h0;
    B_i     = 32'h0;
    repeat (3) tick();
    check("reset busy", {31'b0, busy_o}, 32'd0);
    check("reset done", {31'b0, done_o}, 32'd0);
    check("reset result", result_o, 32'h0);
    reset = 1'b1;
    tick();
    check("post-reset busy", {31'b0, busy_o}, 32'd0);

    for (int i = 0; i < 20; i++) run_op(vecs[i], i);

    // start pulsed mid-MUL must not disturb the running operation
    start_i = 1'b1; op_i = C_OP_MUL; A_i = 32'h7; B_i = 32'hFFFF_FFFD;
    tick();
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 10) begin
        start_i = 1'b1; op_i = C_OP_DIVU; A_i = 32'h9; B_i = 32'h0;
      end else begin
        start_i = 1'b0;
      end
      if (done_o) begin
        lat = n;
        break;
      end
      tick();
    end
    start_i = 1'b0;
    check("ignored start result", result_o, 32'hFFFF_FFEB);
    check("ignored start latency", 32'(lat), 32'd33);
    tick();

    // start held through DONE: second op follows with no IDLE cycle
    start_i = 1'b1; op_i = C_OP_MUL; A_i = 32'd3; B_i = 32'd5;
    tick();
    A_i = 32'd6; B_i = 32'd7;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (done_o) begin
        lat = n;
        break;
      end
      tick();
    end
    check("b2b first latency", 32'(lat), 32'd33);
    check("b2b first result", result_o, 32'd15);
    tick();
    start_i = 1'b0;
    check("b2b second busy", {31'b0, busy_o}, 32'd1);
    check("b2b no double done", {31'b0, done_o}, 32'd0);
    lat = 0;
    seen = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done_o) begin
        lat = n;
        break;
      end
      if (result_o !== 32'd15) seen = 1'b1;
      tick();
    end
    check("b2b result held", {31'b0, seen}, 32'd0);
    check("b2b second latency", 32'(lat), 32'd33);
    check("b2b second result", result_o, 32'd42);
    tick();

    // back-to-back special cases give consecutive done pulses
    start_i = 1'b1; op_i = C_OP_DIVU; A_i = 32'd5; B_i = 32'd0;
    tick();
    check("b2b special first done", {31'b0, done_o}, 32'd1);
    check("b2b special first result", result_o, 32'hFFFF_FFFF);
    op_i = C_OP_REMU; A_i = 32'd9;
    tick();
    start_i = 1'b0;
    check("b2b special second done", {31'b0, done_o}, 32'd1);
    check("b2b special second result", result_o, 32'd9);
    tick();

    // reset at k+15 aborts the MUL with no done pulse
    start_i = 1'b1; op_i = C_OP_MUL; A_i = 32'h7; B_i = 32'hFFFF_FFFD;
    tick();
    start_i = 1'b0;
    repeat (14) tick();
    check("pre-abort busy", {31'b0, busy_o}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort busy", {31'b0, busy_o}, 32'd0);
    check("abort done", {31'b0, done_o}, 32'd0);
    check("abort result", result_o, 32'h0);
    tick();
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_o || busy_o) seen = 1'b1;
      tick();
    end
    check("abort no done", {31'b0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
